// File: rtl/char_disp_pkg.sv
// Purpose : shared types and constants for the character display arbiter.
// Latency : n/a (package only).
// Backpressure : n/a (package only).
//
// Contents: FSM state encoding, display geometry (4 columns, 2-bit column
// index), default character width, and an index-width helper.
package char_disp_pkg;

    // FSM states: wait for a request, fetch one character, sweep it across
    // the display columns.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SCAN  = 2'd2
    } state_e;

    localparam int NUM_COLS   = 4;
    localparam int COL_W      = 2;
    localparam int DEF_CHAR_W = 8;

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);

    // Width of an index into n sources; a single source still needs one bit
    // so the index signals never collapse to zero width.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/char_display_arbiter_rr_arbiter.sv
// Purpose : combinational round-robin pick of one requester.
// Latency : combinational, zero cycles.
// Backpressure : none; the caller decides when the pick is registered.
//
// Ports:
//   req      - request vector, one bit per source
//   ptr      - index of the most recently served source; the search starts at
//              ptr+1 and wraps, so ptr itself has lowest priority
//   pick_oh  - one-hot winner (zero when no request)
//   pick_idx - binary index of the winner (zero when no request)
//   pick_vld - at least one request present
module rr_arbiter
    import char_disp_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  pick_oh,
    output logic [IW-1:0] pick_idx,
    output logic          pick_vld
);

    // Source index reached after stepping off positions past p, with wrap.
    function automatic int wrap_idx(input int p, input int off);
        return (p + off) % N;
    endfunction

    always_comb begin
        pick_oh  = '0;
        pick_idx = '0;
        pick_vld = 1'b0;
        // Visit ptr+1, ptr+2, ..., ptr+N (== ptr) and keep the first hit.
        for (int off = 1; off <= N; off++) begin
            if (!pick_vld && req[wrap_idx(int'(ptr), off)]) begin
                pick_vld                          = 1'b1;
                pick_oh[wrap_idx(int'(ptr), off)] = 1'b1;
                pick_idx                          = IW'(wrap_idx(int'(ptr), off));
            end
        end
    end

endmodule

// File: rtl/char_display_arbiter.sv
// Purpose : shares one 4-column character display write port between NUM_REQ sources.
// Latency : 1 cycle from character acceptance to the first column write; 5 cycles min per character.
// Backpressure : req_ready is high only for the owner while fetching; the display is never stalled mid-character.
//
// Ports:
//   clk, rst    - clock and synchronous active-high reset
//   req         - per-source request, held for the whole message
//   req_valid   - per-source character valid
//   req_char    - per-source character, source i at [i*CHAR_W +: CHAR_W]
//   req_last    - final character of the message (qualified by req_valid)
//   req_ready   - per-source ready; character taken on valid & ready
//   grant       - one-hot owner of the display, zero when idle
//   busy        - |grant
//   write       - display write strobe
//   char_out    - character presented to the display
//   column      - column being written
//   msg_done    - one-cycle pulse after the last column of a message's final character
module char_display_arbiter
    import char_disp_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int CHAR_W  = DEF_CHAR_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*CHAR_W-1:0] req_char,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy,
    output logic                      write,
    output logic [CHAR_W-1:0]         char_out,
    output logic [COL_W-1:0]          column,
    output logic                      msg_done
);

    localparam int IW = idx_width(NUM_REQ);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_FETCH = FETCH;
    localparam logic [1:0] S_SCAN  = SCAN;

    // After reset the pointer sits on the highest index so the upward search
    // from pointer+1 lands on source 0 first.
    localparam logic [IW-1:0] PTR_RST = IW'(NUM_REQ - 1);

    logic [1:0]         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IW-1:0]      gidx_q,  gidx_d;
    logic [IW-1:0]      ptr_q,   ptr_d;
    logic [COL_W-1:0]   col_q,   col_d;
    logic [CHAR_W-1:0]  char_q,  char_d;
    logic               last_q,  last_d;
    logic               done_q,  done_d;

    logic [NUM_REQ-1:0] pick_oh;
    logic [IW-1:0]      pick_idx;
    logic               pick_vld;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr (
        .req      (req),
        .ptr      (ptr_q),
        .pick_oh  (pick_oh),
        .pick_idx (pick_idx),
        .pick_vld (pick_vld)
    );

    // Owner's handshake inputs, selected by the registered grant index.
    logic              own_req;
    logic              own_vld;
    logic              own_last;
    logic [CHAR_W-1:0] own_char;

    always_comb begin
        own_req  = req[gidx_q];
        own_vld  = req_valid[gidx_q];
        own_last = req_last[gidx_q];
        own_char = req_char[int'(gidx_q)*CHAR_W +: CHAR_W];
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        col_d   = col_q;
        char_d  = char_q;
        last_d  = last_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Grant is already zero here; registering a pick always
                // costs this one idle cycle between messages.
                if (pick_vld) begin
                    grant_d = pick_oh;
                    gidx_d  = pick_idx;
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                if (own_vld) begin
                    char_d  = own_char;
                    last_d  = own_last;
                    col_d   = '0;
                    state_d = S_SCAN;
                end else if (!own_req) begin
                    // Owner walked away between characters: release without
                    // a completion pulse, and let the others go first.
                    grant_d = '0;
                    ptr_d   = gidx_q;
                    state_d = S_IDLE;
                end
            end

            S_SCAN: begin
                // Request changes are ignored here; a character always
                // finishes its full column sweep.
                if (col_q == LAST_COL) begin
                    if (last_q) begin
                        done_d  = 1'b1;
                        grant_d = '0;
                        ptr_d   = gidx_q;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end else begin
                    col_d = col_q + 1'b1;
                end
            end

            default: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= PTR_RST;
            col_q   <= '0;
            char_q  <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            col_q   <= col_d;
            char_q  <= char_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    // Ready is a pure function of state and grant so a source sees it
    // without waiting on its own valid.
    assign req_ready = (state_q == S_FETCH) ? grant_q : '0;
    assign write     = (state_q == S_SCAN);
    assign grant     = grant_q;
    assign busy      = |grant_q;
    assign char_out  = char_q;
    assign column    = col_q;
    assign msg_done  = done_q;

endmodule

// File: tb/tb_char_display_arbiter.sv
// Purpose : self-checking bench for char_display_arbiter (NUM_REQ=2, CHAR_W=8).
// Latency : expected writes and msg_done are stamped with the cycle they must appear in.
// Backpressure : per-character stall gaps are modelled on the source side.
module tb_char_display_arbiter;

    localparam int N  = 2;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req, req_valid, req_last, req_ready, grant;
    logic [N*CW-1:0] req_char;
    logic          busy, write, msg_done;
    logic [CW-1:0] char_out;
    logic [1:0]    column;

    always #5 clk = ~clk;

    char_display_arbiter #(.NUM_REQ(N), .CHAR_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_valid (req_valid),
        .req_char  (req_char),
        .req_last  (req_last),
        .req_ready (req_ready),
        .grant     (grant),
        .busy      (busy),
        .write     (write),
        .char_out  (char_out),
        .column    (column),
        .msg_done  (msg_done)
    );

    typedef struct {
        logic [7:0] ch;
        logic [1:0] col;
        int         cyc;
    } wr_t;

    // Table record: stimulus (mask, strings) and expectations (first grant).
    typedef struct {
        logic [1:0]  mask;
        logic [23:0] s0;
        int          l0;
        logic [23:0] s1;
        int          l1;
        int          first;
    } vec_t;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int done_seen = 0;
    int stall_cycles = 0;
    bit stall_watch = 0;

    wr_t        exp_wr[$];
    int         exp_done[$];
    int         exp_gnt[$];
    logic [7:0] src_q [N][$];
    int         gap_q [N][$];
    int         gap_cnt [N];
    logic [N-1:0] src_en = '0;
    logic [N-1:0] rogue  = '0;
    logic [N-1:0] prev_grant = '0;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: check outputs at the falling edge, drive sources,
    // then resolve the handshake that the next rising edge will commit.
    task automatic step();
        wr_t e;
        bit  due;
        logic [7:0] ch;
        int  gexp;
        @(negedge clk);
        cyc++;
        if (!rst) begin
            check("grant_onehot", 32'($onehot0(grant)), 1);
            check("busy", busy, |grant);
            if (req_ready != '0) check("ready_matches_grant", req_ready, grant);
            due = (exp_wr.size() > 0) && (exp_wr[0].cyc == cyc);
            check("write_strobe", write, due);
            if (write && due) begin
                e = exp_wr.pop_front();
                check("char_out", char_out, e.ch);
                check("column", column, e.col);
                check("ready_during_write", req_ready, 0);
            end
            due = (exp_done.size() > 0) && (exp_done[0] == cyc);
            check("msg_done", msg_done, due);
            if (msg_done) begin
                done_seen++;
                check("grant_at_done", grant, 0);
            end
            if (due) void'(exp_done.pop_front());
            if (grant != prev_grant && grant != '0) begin
                if (exp_gnt.size() > 0) gexp = 1 << exp_gnt.pop_front();
                else gexp = 0;
                check("grant_order", grant, gexp);
            end
            prev_grant = grant;
            if (stall_watch && grant == 2'b01 && !write && src_q[0].size() == 1) begin
                stall_cycles++;
                check("stall_column", column, 3);
                check("stall_ready", req_ready, 2'b01);
            end
            if (rogue[1] && write) check("char_not_Z", char_out == 8'h5A, 0);
        end
        for (int i = 0; i < N; i++) begin
            req[i] = src_en[i];
            if (rogue[i]) begin
                req_valid[i] = 1'b1;
                req_char[i*CW +: CW] = 8'h5A;
                req_last[i] = 1'b0;
            end else if (src_en[i] && src_q[i].size() > 0 && gap_cnt[i] == 0) begin
                req_valid[i] = 1'b1;
                req_char[i*CW +: CW] = src_q[i][0];
                req_last[i] = (src_q[i].size() == 1);
            end else begin
                req_valid[i] = 1'b0;
                req_char[i*CW +: CW] = '0;
                req_last[i] = 1'b0;
            end
        end
        #1;
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                if (rogue[i]) check("rogue_ready", req_ready[i], 0);
                if (req_valid[i] && req_ready[i] && !rogue[i]) begin
                    ch = src_q[i].pop_front();
                    for (int c = 0; c < 4; c++)
                        exp_wr.push_back('{ch: ch, col: 2'(c), cyc: cyc + 1 + c});
                    gap_cnt[i] = (gap_q[i].size() > 0) ? gap_q[i].pop_front() : 0;
                    if (src_q[i].size() == 0) begin
                        exp_done.push_back(cyc + 5);
                        src_en[i] = 1'b0;
                    end
                end else if (req_ready[i] && gap_cnt[i] > 0) begin
                    gap_cnt[i]--;
                end
            end
        end
    endtask

    // Queue a message of len chars (MSB-first in s); stall2 idle fetch cycles
    // precede the second character.
    task automatic load(input int i, input logic [23:0] s, input int len, input int stall2);
        for (int k = 0; k < len; k++) begin
            src_q[i].push_back(s[(len-1-k)*8 +: 8]);
            gap_q[i].push_back((k == 1) ? stall2 : 0);
        end
        gap_cnt[i] = gap_q[i].pop_front();
        src_en[i]  = 1'b1;
    endtask

    function automatic bit quiet();
        bit q;
        q = (src_en == '0) && (exp_wr.size() == 0) && (exp_done.size() == 0)
            && (exp_gnt.size() == 0) && (grant == '0);
        for (int i = 0; i < N; i++) if (src_q[i].size() != 0) q = 1'b0;
        return q;
    endfunction

    task automatic run_until(input int budget, input string name);
        bit q;
        q = quiet();
        for (int k = 0; k < budget && !q; k++) begin
            step();
            q = quiet();
        end
        check(name, q, 1);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_grant"}, grant, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_write"}, write, 0);
        check({tag, "_char_out"}, char_out, 0);
        check({tag, "_column"}, column, 0);
        check({tag, "_msg_done"}, msg_done, 0);
        check({tag, "_req_ready"}, req_ready, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  d0;
        bit  hit;
        vecs[0] = '{mask: 2'b11, s0: 24'("X"),  l0: 1, s1: 24'("Y"),   l1: 1, first: 0};
        vecs[1] = '{mask: 2'b11, s0: 24'("X"),  l0: 1, s1: 24'("Y"),   l1: 1, first: 0};
        vecs[2] = '{mask: 2'b01, s0: 24'("AB"), l0: 2, s1: 24'h0,      l1: 0, first: 0};
        vecs[3] = '{mask: 2'b11, s0: 24'("P"),  l0: 1, s1: 24'("Q"),   l1: 1, first: 1};
        vecs[4] = '{mask: 2'b10, s0: 24'h0,     l0: 0, s1: 24'("CDE"), l1: 3, first: 1};
        vecs[5] = '{mask: 2'b11, s0: 24'("GH"), l0: 2, s1: 24'("I"),   l1: 1, first: 0};

        for (int i = 0; i < N; i++) gap_cnt[i] = 0;
        req = '0; req_valid = '0; req_last = '0; req_char = '0;
        rst = 1'b1;
        step();
        step();
        check_zero_outputs("reset");
        rst = 1'b0;

        // Table-driven arbitration rounds.
        for (int v = 0; v < 6; v++) begin
            d0 = done_seen;
            if (vecs[v].mask[0]) load(0, vecs[v].s0, vecs[v].l0, 0);
            if (vecs[v].mask[1]) load(1, vecs[v].s1, vecs[v].l1, 0);
            if (vecs[v].mask == 2'b11) begin
                exp_gnt.push_back(vecs[v].first);
                exp_gnt.push_back(1 - vecs[v].first);
            end else begin
                exp_gnt.push_back(vecs[v].mask[1] ? 1 : 0);
            end
            run_until(200, "vec_complete");
            check("vec_done_count", done_seen - d0, 32'(vecs[v].mask[0]) + 32'(vecs[v].mask[1]));
        end

        // Stall before the second character: column holds 3, write low.
        stall_watch  = 1'b1;
        stall_cycles = 0;
        load(0, 24'("MN"), 2, 3);
        exp_gnt.push_back(0);
        run_until(100, "stall_complete");
        stall_watch = 1'b0;
        check("stall_cycle_count", stall_cycles, 4);

        // Non-owner streams 'Z' with req low while source 0 owns the display.
        load(0, 24'("RS"), 2, 0);
        rogue[1] = 1'b1;
        exp_gnt.push_back(0);
        run_until(100, "rogue_complete");
        rogue[1] = 1'b0;

        // Owner drops req in FETCH with valid low; pending source 1 follows.
        src_en[0] = 1'b1;
        exp_gnt.push_back(0);
        hit = 1'b0;
        for (int k = 0; k < 20 && !hit; k++) begin
            step();
            hit = (grant == 2'b01);
        end
        check("abort_granted", grant, 2'b01);
        src_en[0] = 1'b0;
        d0 = done_seen;
        load(1, 24'("K"), 1, 0);
        exp_gnt.push_back(1);
        run_until(100, "abort_complete");
        check("abort_done_count", done_seen - d0, 1);

        // Reset in the middle of a SCAN at column 2.
        load(0, 24'("UV"), 2, 0);
        exp_gnt.push_back(0);
        hit = 1'b0;
        for (int k = 0; k < 100 && !hit; k++) begin
            step();
            hit = write && (column == 2'd2);
        end
        check("reached_col2", hit, 1);
        rst = 1'b1;
        exp_wr.delete();
        exp_done.delete();
        exp_gnt.delete();
        for (int i = 0; i < N; i++) begin
            src_q[i].delete();
            gap_q[i].delete();
            gap_cnt[i] = 0;
        end
        src_en = '0;
        step();
        check_zero_outputs("midreset");
        rst = 1'b0;
        prev_grant = '0;
        load(0, 24'("a"), 1, 0);
        load(1, 24'("b"), 1, 0);
        exp_gnt.push_back(0);
        exp_gnt.push_back(1);
        run_until(100, "post_reset_complete");

        check("scoreboard_empty", exp_wr.size() + exp_done.size() + exp_gnt.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
